// File: rtl/gate_sweep_sequencer.sv
// Sweeps the gate inputs {Y,X,B,A} through 0..15, dwells on each, and captures F into a truth table.
// Optional GATE_SWEEP_CHECK_EN adds a compare against expected_in with mismatch/fail_idx outputs.
module gate_sweep_sequencer #(
  parameter int DWELL_CYCLES = 4,
  parameter bit AUTO_REPEAT  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f_in,
`ifdef GATE_SWEEP_CHECK_EN
  input  logic [15:0] expected_in,
  output logic        mismatch,
  output logic [3:0]  fail_idx,
`endif
  output logic        a_out,
  output logic        b_out,
  output logic        x_out,
  output logic        y_out,
  output logic        busy,
  output logic        done,
  output logic        table_valid,
  output logic [15:0] truth_table
);
  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    vec_q, vec_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;
  logic [15:0]   table_q, table_d;
`ifdef GATE_SWEEP_CHECK_EN
  logic          mis_q, mis_d;
  logic [3:0]    fidx_q, fidx_d;
  logic [15:0]   diff;
  logic [3:0]    low;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    table_d = table_q;
`ifdef GATE_SWEEP_CHECK_EN
    mis_d  = mis_q;
    fidx_d = fidx_q;
    diff   = table_q ^ expected_in;
    low    = 4'd0;
    // Scan downward so the last hit is the lowest differing index.
    for (int i = 15; i >= 0; i--) begin
      if (diff[i]) low = 4'(i);
    end
`endif
    case (state_q)
      S_IDLE: begin
        vec_d  = 4'd0;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_RUN;
          idx_d   = 4'd0;
          cnt_d   = '0;
          table_d = 16'd0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
`ifdef GATE_SWEEP_CHECK_EN
          mis_d  = 1'b0;
          fidx_d = 4'd0;
`endif
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          table_d[idx_q] = f_in;
          cnt_d          = '0;
          if (idx_q == 4'hF) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            valid_d = 1'b1;
            vec_d   = 4'hF;
          end else begin
            idx_d = idx_q + 4'd1;
            vec_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
`ifdef GATE_SWEEP_CHECK_EN
        // The final capture landed on the edge entering DONE, so the table is complete here.
        mis_d  = |diff;
        fidx_d = low;
`endif
        idx_d = 4'd0;
        cnt_d = '0;
        vec_d = 4'd0;
        if (AUTO_REPEAT) begin
          state_d = S_RUN;
          table_d = 16'd0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        vec_d   = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= '0;
      vec_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      table_q <= 16'd0;
`ifdef GATE_SWEEP_CHECK_EN
      mis_q   <= 1'b0;
      fidx_q  <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      table_q <= table_d;
`ifdef GATE_SWEEP_CHECK_EN
      mis_q   <= mis_d;
      fidx_q  <= fidx_d;
`endif
    end
  end

  assign {y_out, x_out, b_out, a_out} = vec_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign table_valid = valid_q;
  assign truth_table = table_q;
`ifdef GATE_SWEEP_CHECK_EN
  assign mismatch = mis_q;
  assign fail_idx = fidx_q;
`endif

endmodule

// File: tb/tb_gate_sweep_sequencer.sv
// Bench for gate_sweep_sequencer: a table of gate functions plus random LUT gates, with timeline checks.
module tb_gate_sweep_sequencer;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        f_in;
  logic        a_out, b_out, x_out, y_out, busy, done, table_valid;
  logic [15:0] truth_table;
  logic [3:0]  vec;
`ifdef GATE_SWEEP_CHECK_EN
  logic [15:0] expected_in = 16'h8888;
  logic        mismatch;
  logic [3:0]  fail_idx;
`endif

  int          fsel = 0;
  logic [15:0] lut = 16'd0;
  int          n_chk = 0;
  int          n_pass = 0;

  gate_sweep_sequencer #(.DWELL_CYCLES(D), .AUTO_REPEAT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in),
`ifdef GATE_SWEEP_CHECK_EN
    .expected_in(expected_in), .mismatch(mismatch), .fail_idx(fail_idx),
`endif
    .a_out(a_out), .b_out(b_out), .x_out(x_out), .y_out(y_out),
    .busy(busy), .done(done), .table_valid(table_valid), .truth_table(truth_table)
  );

  always #5 clk = ~clk;

  assign vec = {y_out, x_out, b_out, a_out};

  // Behavioural gate under test: combinational on the sequencer outputs.
  always_comb begin
    f_in = 1'b0;
    case (fsel)
      0:       f_in = a_out & b_out;
      1:       f_in = a_out ^ b_out;
      2:       f_in = y_out;
      3:       f_in = x_out | a_out;
      5:       f_in = (a_out & b_out) | (vec == 4'd5);
      default: f_in = lut[vec];
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Caller is at a negedge. k counts negedges after the edge that samples start.
  task automatic run_sweep(input int fs, input logic [15:0] exp, input int p1, input int p2,
                           input bit hold, input int ab);
    fsel  = fs;
    start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 66; k++) begin
      if (k == ab) begin
        chk("abort_vec", {28'd0, vec}, 32'((k - 1) / D));
        #2 rst_n = 1'b0;
        #1 chk("abort_outs", {busy, done, table_valid, vec, truth_table}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
      if (k == 1) chk("table_cleared", {15'd0, table_valid, truth_table}, 32'd0);
      if (k <= 64)
        chk("run", {busy, done, table_valid, vec}, {1'b1, 1'b0, 1'b0, 4'((k - 1) / D)});
      if (k == 65) begin
        chk("done", {busy, done, table_valid, vec}, {1'b1, 1'b1, 1'b1, 4'hF});
        chk("table", {16'd0, truth_table}, {16'd0, exp});
      end
      if (k == 66) begin
        chk("idle_after", {busy, done, table_valid, vec}, {1'b0, 1'b0, 1'b1, 4'h0});
        chk("table_held", {16'd0, truth_table}, {16'd0, exp});
`ifdef GATE_SWEEP_CHECK_EN
        begin
          logic [3:0] lo;
          lo = 4'd0;
          for (int i = 0; i < 16; i++)
            if (exp[i] != expected_in[i]) begin lo = 4'(i); break; end
          chk("mismatch", {27'd0, mismatch, fail_idx}, {27'd0, exp != expected_in, lo});
        end
`endif
      end
      start = hold || (k == p1) || (k == p2);
      if (k < 66) @(negedge clk);
    end
  endtask

  typedef struct {
    int          fs;
    logic [15:0] exp;
    int          p1;
    int          p2;
    bit          hold;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{0, 16'h8888, -1, -1, 1'b0};
    tbl[1] = '{1, 16'h6666, -1, -1, 1'b1};  // start held: relaunch straight after DONE
    tbl[2] = '{2, 16'hFF00, -1, -1, 1'b0};
    tbl[3] = '{0, 16'h8888, 10, 30, 1'b0};  // start pulses while busy are ignored
    tbl[4] = '{3, 16'hFAFA, -1, -1, 1'b0};
    tbl[5] = '{5, 16'h88A8, -1, -1, 1'b0};

    // Async reset from an unknown state, mid-cycle, without any clock edge.
    #12 rst_n = 1'b0;
    #1 chk("reset_outs", {busy, done, table_valid, vec, truth_table}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_stays", {busy, done, table_valid, vec, truth_table}, 32'd0);

    for (int i = 0; i < 6; i++)
      run_sweep(tbl[i].fs, tbl[i].exp, tbl[i].p1, tbl[i].p2, tbl[i].hold, -1);

    // Abort at idx 7, then a full sweep must still run cleanly.
    run_sweep(0, 16'h8888, -1, -1, 1'b0, 7 * D + 1);
    run_sweep(0, 16'h8888, -1, -1, 1'b0, -1);

    for (int r = 0; r < 6; r++) begin
      lut = 16'($urandom);
      run_sweep(4, lut, int'($urandom_range(2, 60)), int'($urandom_range(2, 64)), 1'b0, -1);
    end

    repeat (3) @(negedge clk);
    chk("final_idle", {30'd0, busy, done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
